pwm_deadtime: RTL



---
 rtl/pwm_deadtime.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pwm_deadtime.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_deadtime
//  Description : Dead-time insertion stage for one PWM leg. Converts a leg
//                command into complementary high-side / low-side gate drives.
//                A programmable blanking interval keeps both drives off
//                between sides. Enable and a latched fault trip force both
//                drives off. Command pulses swallowed by the dead band are
//                counted in a saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_deadtime #(
    parameter int DT_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic                 enable_i,
    input  logic                 trip_i,
    input  logic                 trip_clear_i,
    input  logic                 PWM_i,
    input  logic [DT_WIDTH-1:0]  deadtime_i,
    output logic                 H_o,
    output logic                 L_o,
    output logic                 tripped_o,
    output logic [CNT_WIDTH-1:0] narrow_cnt_o
);

    // ------------------------------------------------------------------------
    // State and side encodings
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_DEAD = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    // Side that was driving just before the current dead interval began.
    typedef enum logic [1:0] {
        SIDE_NONE = 2'd0,
        SIDE_HIGH = 2'd1,
        SIDE_LOW  = 2'd2
    } side_t;

    localparam logic [DT_WIDTH-1:0]  c_dt_one  = DT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DT_WIDTH-1:0]    r_dt_cnt;
    logic [DT_WIDTH-1:0]    w_dt_cnt_nxt;
    side_t                  r_prev_side;
    side_t                  w_prev_side_nxt;

    logic                   r_tripped;
    logic                   w_tripped_nxt;
    logic                   w_force_off;
    logic [DT_WIDTH-1:0]    w_dt_load;

    logic                   w_narrow_hit;
    logic                   r_narrow_hit;
    logic [CNT_WIDTH-1:0]   r_narrow_cnt;

    logic                   w_h_nxt;
    logic                   w_l_nxt;
    logic                   r_h;
    logic                   r_l;

    // ------------------------------------------------------------------------
    // Trip latch and force-off qualification
    // ------------------------------------------------------------------------
    // A live trip always wins over a clear issued in the same cycle, so the
    // latch only releases once the fault source itself has gone quiet.
    assign w_tripped_nxt = trip_i | (r_tripped & ~trip_clear_i);

    // Uses the registered latch, so after a clear the leg spends one more
    // cycle in OFF before the restart interval begins.
    assign w_force_off = ~enable_i | trip_i | r_tripped;

    // A zero setting behaves as one cycle: the two drives may never overlap
    // or hand over on the same edge.
    assign w_dt_load = (deadtime_i == '0) ? c_dt_one : deadtime_i;

    // ------------------------------------------------------------------------
    // Next-state, dead-band counter and narrow-pulse detection
    // ------------------------------------------------------------------------
    // Decide the next leg state; force-off overrides every other transition.
    always_comb begin
        w_state_nxt     = r_state;
        w_dt_cnt_nxt    = r_dt_cnt;
        w_prev_side_nxt = r_prev_side;
        w_narrow_hit    = 1'b0;

        if (w_force_off) begin
            w_state_nxt     = S_OFF;
            w_dt_cnt_nxt    = '0;
            w_prev_side_nxt = SIDE_NONE;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt     = S_DEAD;
                    w_dt_cnt_nxt    = w_dt_load;
                    w_prev_side_nxt = SIDE_NONE;
                end
                S_HIGH: begin
                    if (!PWM_i) begin
                        w_state_nxt     = S_DEAD;
                        w_dt_cnt_nxt    = w_dt_load;
                        w_prev_side_nxt = SIDE_HIGH;
                    end
                end
                S_LOW: begin
                    if (PWM_i) begin
                        w_state_nxt     = S_DEAD;
                        w_dt_cnt_nxt    = w_dt_load;
                        w_prev_side_nxt = SIDE_LOW;
                    end
                end
                S_DEAD: begin
                    // The command level at expiry picks the side; toggles
                    // earlier in the interval do not restart the count.
                    // A count of zero cannot occur here, but is treated as
                    // expiry so the state can never stall.
                    if (r_dt_cnt <= c_dt_one) begin
                        w_state_nxt  = PWM_i ? S_HIGH : S_LOW;
                        w_dt_cnt_nxt = '0;
                        w_narrow_hit = ( PWM_i && (r_prev_side == SIDE_HIGH)) ||
                                       (!PWM_i && (r_prev_side == SIDE_LOW));
                    end else begin
                        w_dt_cnt_nxt = r_dt_cnt - c_dt_one;
                    end
                end
                default: begin
                    w_state_nxt     = S_OFF;
                    w_dt_cnt_nxt    = '0;
                    w_prev_side_nxt = SIDE_NONE;
                end
            endcase
        end
    end

    // Drives are decoded from the next state so they change on the same edge
    // as the state itself; only one of them can ever be set.
    assign w_h_nxt = (w_state_nxt == S_HIGH);
    assign w_l_nxt = (w_state_nxt == S_LOW);

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    // Leg state, dead-band counter and the side recorded on entry to DEAD.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state     <= S_OFF;
            r_dt_cnt    <= '0;
            r_prev_side <= SIDE_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_dt_cnt    <= w_dt_cnt_nxt;
            r_prev_side <= w_prev_side_nxt;
        end
    end

    // Registered gate drives; reset clears them without waiting for a clock.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_h <= 1'b0;
            r_l <= 1'b0;
        end else begin
            r_h <= w_h_nxt;
            r_l <= w_l_nxt;
        end
    end

    // Fault trip latch.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_tripped <= 1'b0;
        end else begin
            r_tripped <= w_tripped_nxt;
        end
    end

    // Narrow-pulse event is staged one cycle, then added to a counter that
    // saturates at all-ones and only reset clears.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_narrow_hit <= 1'b0;
            r_narrow_cnt <= '0;
        end else begin
            r_narrow_hit <= w_narrow_hit;
            if (r_narrow_hit && (r_narrow_cnt != c_cnt_max)) begin
                r_narrow_cnt <= r_narrow_cnt + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign H_o          = r_h;
    assign L_o          = r_l;
    assign tripped_o    = r_tripped;
    assign narrow_cnt_o = r_narrow_cnt;

endmodule
`default_nettype wire
